// File: rtl/lu_pkg.sv
// Shared definitions for the LU-factorization frame sequencing logic.
package lu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      PH_LOAD  = 2'd0,
      PH_DIV   = 2'd1,
      PH_ELIM  = 2'd2,
      PH_STORE = 2'd3
   } phase_e;

   localparam int unsigned LU_LIMIT    = 21;
   localparam int unsigned LU_N        = 4;
   localparam int unsigned LU_LOAD_LEN = 4;
   localparam int unsigned LU_DIV_LEN  = 4;
   localparam int unsigned LU_ELIM_LEN = 10;
   localparam int unsigned LU_CNT_W    = 5;
   localparam int unsigned LU_COL_W    = 2;

   // Successor of a global counter value, wrapping LIMIT -> 0.
   function automatic logic [LU_CNT_W-1:0] next_count(
      input logic [LU_CNT_W-1:0] c,
      input logic [LU_CNT_W-1:0] lim
   );
      return (c == lim) ? '0 : c + 1'b1;
   endfunction

endpackage

// File: rtl/lu_phase_decode.sv
// Combinational map from frame count to datapath phase.
module lu_phase_decode
   import lu_pkg::*;
#(
   parameter int unsigned LOAD_LEN = LU_LOAD_LEN,
   parameter int unsigned DIV_LEN  = LU_DIV_LEN,
   parameter int unsigned ELIM_LEN = LU_ELIM_LEN
) (
   input  logic [LU_CNT_W-1:0] count,
   output phase_e              phase
);

   localparam logic [LU_CNT_W-1:0] LOAD_END = LU_CNT_W'(LOAD_LEN);
   localparam logic [LU_CNT_W-1:0] DIV_END  = LU_CNT_W'(LOAD_LEN + DIV_LEN);
   localparam logic [LU_CNT_W-1:0] ELIM_END = LU_CNT_W'(LOAD_LEN + DIV_LEN + ELIM_LEN);

   // Phase boundaries are cumulative; store takes whatever is left of the frame.
   always_comb begin
      phase = PH_STORE;
      if (count < LOAD_END) begin
         phase = PH_LOAD;
      end else if (count < DIV_END) begin
         phase = PH_DIV;
      end else if (count < ELIM_END) begin
         phase = PH_ELIM;
      end
   end

endmodule

// File: rtl/lu_frame_sequencer.sv
// Steps column k through one global-counter frame each, emitting phase strobes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; col and err hold their last values
// SYNC  | run requested, waiting for count==LIMIT to align to a frame
// RUN   | one frame per column, strobes registered from sampled count
// DONE  | one-cycle done pulse, busy already low
module lu_frame_sequencer
   import lu_pkg::*;
#(
   parameter int unsigned LIMIT    = LU_LIMIT,
   parameter int unsigned N        = LU_N,
   parameter int unsigned LOAD_LEN = LU_LOAD_LEN,
   parameter int unsigned DIV_LEN  = LU_DIV_LEN,
   parameter int unsigned ELIM_LEN = LU_ELIM_LEN
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [LU_CNT_W-1:0] count,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [LU_COL_W-1:0] col,
   output logic                load_en,
   output logic                div_en,
   output logic                elim_en,
   output logic                store_en,
   output logic                err
);

   if (LOAD_LEN + DIV_LEN + ELIM_LEN > LIMIT) begin : g_bad_phase_lens
      $error("lu_frame_sequencer: load+div+elim lengths exceed the frame limit");
   end

   localparam logic [LU_CNT_W-1:0] LIM      = LU_CNT_W'(LIMIT);
   localparam logic [LU_COL_W-1:0] COL_LAST = LU_COL_W'(N - 2);

   state_e              state_q, state_d;
   logic [LU_COL_W-1:0] col_q, col_d;
   logic [LU_CNT_W-1:0] prev_q, prev_d;
   logic [3:0]          strb_q, strb_d;   // {load, div, elim, store}
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   phase_e              phase;

   lu_phase_decode #(
      .LOAD_LEN (LOAD_LEN),
      .DIV_LEN  (DIV_LEN),
      .ELIM_LEN (ELIM_LEN)
   ) u_phase_decode (
      .count (count),
      .phase (phase)
   );

   // Next-state and registered-output logic; a broken count sequence aborts the run.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      prev_d  = count;
      strb_d  = 4'b0000;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               state_d = ST_SYNC;
               busy_d  = 1'b1;
               err_d   = 1'b0;
               col_d   = '0;
            end
         end
         ST_SYNC: begin
            busy_d = 1'b1;
            if (count == LIM) begin
               state_d = ST_RUN;
               col_d   = '0;
            end
         end
         ST_RUN: begin
            if (count != next_count(prev_q, LIM)) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               case (phase)
                  PH_LOAD:  strb_d = 4'b1000;
                  PH_DIV:   strb_d = 4'b0100;
                  PH_ELIM:  strb_d = 4'b0010;
                  PH_STORE: strb_d = 4'b0001;
                  default:  strb_d = 4'b0000;
               endcase
               if (count == LIM) begin
                  if (col_q == COL_LAST) begin
                     state_d = ST_DONE;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         col_q   <= '0;
         prev_q  <= '0;
         strb_q  <= 4'b0000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         prev_q  <= prev_d;
         strb_q  <= strb_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign col      = col_q;
   assign err      = err_q;
   assign load_en  = strb_q[3];
   assign div_en   = strb_q[2];
   assign elim_en  = strb_q[1];
   assign store_en = strb_q[0];

endmodule

// File: tb/tb_lu_frame_sequencer.sv
// Directed bench for lu_frame_sequencer (N=4 main instance, N=2 side instance).
module tb_lu_frame_sequencer;
   import lu_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       start2;
   logic [4:0] count;
   logic       busy, done, err, load_en, div_en, elim_en, store_en;
   logic [1:0] col;
   logic       busy2, done2, err2, load_en2, div_en2, elim_en2, store_en2;
   logic [1:0] col2;
   logic [3:0] strb, strb2;
   logic [4:0] last;
   int         checks = 0;
   int         failures = 0;
   int         n;
   int         nstr;

   always #5 clk = ~clk;

   assign strb  = {load_en, div_en, elim_en, store_en};
   assign strb2 = {load_en2, div_en2, elim_en2, store_en2};

   lu_frame_sequencer dut (
      .clk(clk), .rst(rst), .count(count), .start(start),
      .busy(busy), .done(done), .col(col),
      .load_en(load_en), .div_en(div_en), .elim_en(elim_en), .store_en(store_en),
      .err(err)
   );

   lu_frame_sequencer #(.N(2)) dut2 (
      .clk(clk), .rst(rst), .count(count), .start(start2),
      .busy(busy2), .done(done2), .col(col2),
      .load_en(load_en2), .div_en(div_en2), .elim_en(elim_en2), .store_en(store_en2),
      .err(err2)
   );

   function automatic logic [3:0] exp_strb(input int c);
      if (c < 4) return 4'b1000;
      else if (c < 8) return 4'b0100;
      else if (c < 18) return 4'b0010;
      else return 4'b0001;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: outputs settle 1 time unit after the edge, then the counter advances.
   task automatic cyc();
      @(posedge clk);
      #1;
      last = count;
      count = (count == 5'd21) ? 5'd0 : count + 5'd1;
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("start_busy", int'(busy), 1);
      chk("start_err_clr", int'(err), 0);
   endtask

   task automatic wait_sync(output int waited);
      waited = 0;
      do begin
         cyc();
         waited++;
      end while (last != 5'd21 && waited < 40);
      chk("sync_found", int'(last), 21);
   endtask

   task automatic run_cycles(input int from, input int to, input int pulse_at);
      int f, c, ec;
      for (int i = from; i < to; i++) begin
         if (i == pulse_at) start = 1'b1;
         cyc();
         start = 1'b0;
         f  = i / 22;
         c  = i % 22;
         ec = (c == 21 && f < 2) ? f + 1 : f;
         chk("run_strb", int'(strb), int'(exp_strb(c)));
         chk("run_col", int'(col), ec);
         chk("run_busy", int'(busy), 1);
         chk("run_done", int'(done), 0);
      end
   endtask

   task automatic run_end();
      cyc();
      chk("end_done", int'(done), 1);
      chk("end_busy", int'(busy), 0);
      chk("end_strb", int'(strb), 0);
      chk("end_col", int'(col), 2);
      chk("end_err", int'(err), 0);
      cyc();
      chk("end_done_pulse", int'(done), 0);
      chk("end_busy_after", int'(busy), 0);
      chk("end_col_hold", int'(col), 2);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start2 = 1'b0; count = 5'd0; last = 5'd0;
      #12;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_strb", int'(strb), 0);
      chk("rst_col", int'(col), 0);
      @(negedge clk);
      rst = 1'b0;
      count = 5'd5;

      // Basic run from mid-frame
      do_start();
      wait_sync(n);
      chk("sync_wait_len", n, 16);
      chk("sync_strb", int'(strb), 0);
      run_cycles(0, 66, -1);
      run_end();

      // start during RUN at col=1 is ignored
      do_start();
      wait_sync(n);
      run_cycles(0, 66, 30);
      run_end();

      // Sequence break 9 -> 12 during elim of column 1
      do_start();
      wait_sync(n);
      run_cycles(0, 32, -1);
      count = 5'd12;
      cyc();
      chk("err_set", int'(err), 1);
      chk("err_strb", int'(strb), 0);
      chk("err_busy", int'(busy), 0);
      chk("err_done", int'(done), 0);
      chk("err_col", int'(col), 1);
      for (int k = 0; k < 30; k++) begin
         cyc();
         chk("err_no_done", int'(done), 0);
         chk("err_sticky", int'(err), 1);
         chk("err_idle", int'(busy), 0);
      end
      do_start();
      wait_sync(n);
      run_cycles(0, 66, -1);
      run_end();

      // Asynchronous reset at col=1, count=15
      do_start();
      wait_sync(n);
      run_cycles(0, 38, -1);
      chk("pre_rst_col", int'(col), 1);
      rst = 1'b1;
      #1;
      chk("arst_busy", int'(busy), 0);
      chk("arst_strb", int'(strb), 0);
      chk("arst_col", int'(col), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_err", int'(err), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 30; k++) begin
         cyc();
         chk("post_rst_done", int'(done), 0);
         chk("post_rst_busy", int'(busy), 0);
         chk("post_rst_strb", int'(strb), 0);
      end

      // N=2 instance: one frame, col stays 0, done after 22 strobe cycles
      start2 = 1'b1;
      cyc();
      start2 = 1'b0;
      chk("n2_busy", int'(busy2), 1);
      wait_sync(n);
      nstr = 0;
      for (int k = 0; k < 22; k++) begin
         cyc();
         chk("n2_strb", int'(strb2), int'(exp_strb(k)));
         chk("n2_col", int'(col2), 0);
         chk("n2_done", int'(done2), 0);
         if (strb2 != 4'b0000) nstr++;
      end
      cyc();
      chk("n2_done_pulse", int'(done2), 1);
      chk("n2_busy_fall", int'(busy2), 0);
      chk("n2_strb_end", int'(strb2), 0);
      chk("n2_strobe_cycles", nstr, 22);
      chk("n2_main_idle", int'(busy), 0);

      // start sampled at count==21 waits a full frame
      for (int k = 0; k < 30 && count != 5'd21; k++) cyc();
      do_start();
      wait_sync(n);
      chk("sync_full_frame", n, 22);
      run_cycles(0, 66, -1);
      run_end();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
